// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-cycle instruction RAM read, skid buffer and valid/ready
// delivery to decode. Optional halt-on-zero-word behaviour is enabled by FETCH_HALT_DETECT_EN.
module fetch_unit #(
    parameter int ADDRESS_BUS_WIDTH = 24,
    parameter int INSTRUCTION_WIDTH = 33,
    parameter int IMEM_WORDS        = 64,
    parameter int RESET_PC          = 0,
    parameter int BUF_DEPTH         = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [ADDRESS_BUS_WIDTH-1:0] iram_address,
    output logic                         iram_read_not_write,
    input  logic [INSTRUCTION_WIDTH-1:0] iram_data,
    output logic                         instr_valid,
    output logic [INSTRUCTION_WIDTH-1:0] instr,
    output logic [ADDRESS_BUS_WIDTH-1:0] instr_pc,
    input  logic                         instr_ready,
    input  logic                         redirect_valid,
    input  logic [ADDRESS_BUS_WIDTH-1:0] redirect_pc,
    output logic                         halted
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 2);
    localparam logic [ADDRESS_BUS_WIDTH-1:0] LAST_PC  = ADDRESS_BUS_WIDTH'(IMEM_WORDS - 1);
    localparam logic [ADDRESS_BUS_WIDTH-1:0] PC_RESET = ADDRESS_BUS_WIDTH'(RESET_PC);
    localparam logic [PTR_W-1:0]             LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W-1:0]             DEPTH_C  = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [ADDRESS_BUS_WIDTH-1:0]   r_pc;
    logic                           r_inflight;
    logic [ADDRESS_BUS_WIDTH-1:0]   r_inflight_pc;
    logic [INSTRUCTION_WIDTH-1:0]   r_buf_instr [BUF_DEPTH];
    logic [ADDRESS_BUS_WIDTH-1:0]   r_buf_pc    [BUF_DEPTH];
    logic [PTR_W-1:0]               r_head;
    logic [PTR_W-1:0]               r_tail;
    logic [CNT_W-1:0]               r_count;
    logic                           r_stop;

    logic                           w_pop;
    logic                           w_push;
    logic                           w_issue;
    logic                           w_stop_set;
    logic                           w_halt_enter;
    logic [CNT_W-1:0]               w_occ;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
    endfunction

    assign instr_valid         = (r_count != {CNT_W{1'b0}});
    assign instr               = instr_valid ? r_buf_instr[r_head] : {INSTRUCTION_WIDTH{1'b0}};
    assign instr_pc            = instr_valid ? r_buf_pc[r_head] : {ADDRESS_BUS_WIDTH{1'b0}};
    assign iram_address        = r_pc;
    assign iram_read_not_write = 1'b1;
    assign w_pop               = instr_valid & instr_ready;
    // Occupancy the buffer will need if the read in flight lands and the head leaves this cycle.
    assign w_occ               = r_count + CNT_W'(r_inflight) - CNT_W'(w_pop);
    assign w_halt_enter        = r_stop & w_pop & (r_count == CNT_W'(1));

`ifdef FETCH_HALT_DETECT_EN
    assign w_stop_set = w_push & (iram_data == {INSTRUCTION_WIDTH{1'b0}});
    assign halted     = (r_state == S_HALTED);
`else
    assign w_stop_set = 1'b0;
    assign halted     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a redirect always lands the machine in RUN unless it is idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!redirect_valid && start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (!redirect_valid && w_halt_enter) begin
                    w_state_nxt = S_HALTED;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
`ifdef FETCH_HALT_DETECT_EN
            S_HALTED: begin
                if (redirect_valid) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_HALTED;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State-dependent controls: issue a read and accept returning data.
    always_comb begin
        w_issue = 1'b0;
        w_push  = 1'b0;
        if ((r_state == S_RUN) && !redirect_valid && !r_stop && (w_occ < DEPTH_C)) begin
            w_issue = 1'b1;
        end else begin
            w_issue = 1'b0;
        end
        if (r_inflight && !redirect_valid && !r_stop) begin
            w_push = 1'b1;
        end else begin
            w_push = 1'b0;
        end
    end

    // Program counter and the tag of the read currently in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= PC_RESET;
            r_inflight    <= 1'b0;
            r_inflight_pc <= {ADDRESS_BUS_WIDTH{1'b0}};
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_inflight_pc <= r_pc;
            r_pc          <= (r_pc == LAST_PC) ? {ADDRESS_BUS_WIDTH{1'b0}} : r_pc + ADDRESS_BUS_WIDTH'(1);
            r_inflight    <= 1'b1;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    // Skid buffer: circular queue, flushed by redirect; r_stop blocks words after a halt word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
            r_stop  <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf_instr[i] <= {INSTRUCTION_WIDTH{1'b0}};
                r_buf_pc[i]    <= {ADDRESS_BUS_WIDTH{1'b0}};
            end
        end else if (redirect_valid) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
            r_stop  <= 1'b0;
        end else begin
            if (w_push) begin
                r_buf_instr[r_tail] <= iram_data;
                r_buf_pc[r_tail]    <= r_inflight_pc;
                r_tail              <= next_ptr(r_tail);
            end
            if (w_pop) begin
                r_head <= next_ptr(r_head);
            end
            if (w_stop_set) begin
                r_stop <= 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected (pc, instr) pairs, a negedge
// monitor pops and compares every accepted handshake.
module tb_fetch_unit;
    localparam int AW = 24;
    localparam int IW = 33;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] iram_address;
    logic          iram_read_not_write;
    logic [IW-1:0] iram_data;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          halted;

    logic [IW-1:0]    mem [64];
    logic [AW+IW-1:0] exp_q [$];
    logic [AW+IW-1:0] mon_exp;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .iram_address        (iram_address),
        .iram_read_not_write (iram_read_not_write),
        .iram_data           (iram_data),
        .instr_valid         (instr_valid),
        .instr               (instr),
        .instr_pc            (instr_pc),
        .instr_ready         (instr_ready),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .halted              (halted)
    );

    // Instruction RAM model with registered read.
    always @(posedge clk) iram_data <= mem[iram_address[5:0]];

    function automatic void push_exp(input logic [AW-1:0] p, input logic [IW-1:0] d);
        exp_q.push_back({p, d});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every accepted head must match the front of the scoreboard.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_delivery actual pc=%0h instr=%0h required=none", instr_pc, instr);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({instr_pc, instr} !== mon_exp) begin
                    errors++;
                    $display("FAIL delivery actual pc=%0h instr=%0h required pc=%0h instr=%0h",
                             instr_pc, instr, mon_exp[AW+IW-1:IW], mon_exp[IW-1:0]);
                end
            end
        end
    end

    // Wait until pc p is at the head, then stall so p is not consumed.
    task automatic wait_head(input logic [AW-1:0] p);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(posedge clk);
            #1;
            if (instr_valid && instr_pc == p) begin
                instr_ready = 1'b0;
                found = 1'b1;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_head actual=timeout required=pc %0h", p);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = IW'(k + 'h100);
        rst = 1'b1; start = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 33'h0);
        check("rst_pc", instr_pc, 24'h0);
        check("rst_halted", halted, 1'b0);
        check("rst_rnw", iram_read_not_write, 1'b1);
        check("rst_addr", iram_address, 24'h0);

        // Latency: start sampled at E0, first valid after E2.
        for (int k = 0; k < 3; k++) push_exp(AW'(k), IW'(k + 'h100));
        instr_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); check("lat_e0_valid", instr_valid, 1'b0);
        @(negedge clk); check("lat_e1_valid", instr_valid, 1'b0);
        @(negedge clk); check("lat_e2_valid", instr_valid, 1'b1);
        check("lat_e2_pc", instr_pc, 24'h0);
        wait_head(24'd3);

        // Backpressure: five stalled cycles with head and fetch address frozen.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_valid", instr_valid, 1'b1);
            check("stall_pc", instr_pc, 24'd3);
            check("stall_instr", instr, 33'h103);
            check("stall_addr", iram_address, 24'd5);
        end
        @(posedge clk); #1;
        for (int k = 3; k < 8; k++) push_exp(AW'(k), IW'(k + 'h100));
        instr_ready = 1'b1;
        wait_head(24'd8);

        // Redirect with a full buffer: stale entries must vanish.
        repeat (3) @(posedge clk);
        #1 redirect_valid = 1'b1; redirect_pc = 24'h20;
        @(posedge clk); #1 redirect_valid = 1'b0;
        for (int k = 'h20; k < 'h23; k++) push_exp(AW'(k), IW'(k + 'h100));
        instr_ready = 1'b1;
        @(negedge clk); check("redir_r0_valid", instr_valid, 1'b0);
        @(negedge clk); check("redir_r1_valid", instr_valid, 1'b0);
        @(negedge clk); check("redir_r2_valid", instr_valid, 1'b1);
        check("redir_r2_pc", instr_pc, 24'h20);
        wait_head(24'h23);

        // Redirect near the top of memory: PC wraps 63 -> 0.
        redirect_valid = 1'b1; redirect_pc = 24'd62;
        @(posedge clk); #1 redirect_valid = 1'b0;
        push_exp(24'd62, 33'h13e);
        push_exp(24'd63, 33'h13f);
        push_exp(24'd0, 33'h100);
        push_exp(24'd1, 33'h101);
        instr_ready = 1'b1;
        wait_head(24'd2);
        check("wrap_queue_empty", exp_q.size(), 0);

        // Reset in the middle of streaming with a read in flight.
        for (int k = 2; k < 5; k++) push_exp(AW'(k), IW'(k + 'h100));
        instr_ready = 1'b1;
        wait_head(24'd5);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_valid", instr_valid, 1'b0);
        check("mrst_addr", iram_address, 24'h0);
        check("mrst_instr", instr, 33'h0);
        check("mrst_pc", instr_pc, 24'h0);
        instr_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("idle_valid", instr_valid, 1'b0);
            check("idle_addr", iram_address, 24'h0);
        end
        check("mrst_queue_empty", exp_q.size(), 0);

        // All-zero instruction at pc 3.
        mem[3] = '0;
        for (int k = 0; k < 3; k++) push_exp(AW'(k), IW'(k + 'h100));
        push_exp(24'd3, 33'h0);
`ifdef FETCH_HALT_DETECT_EN
        begin
            bit seen;
            seen = 1'b0;
            pulse_start();
            for (int i = 0; i < 60 && !seen; i++) begin
                @(posedge clk); #1;
                if (halted) seen = 1'b1;
            end
            check("halt_reached", seen, 1'b1);
        end
        check("halt_valid", instr_valid, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("halt_no_more", instr_valid, 1'b0);
            check("halt_flag", halted, 1'b1);
        end
        check("halt_queue_empty", exp_q.size(), 0);
        mem[3] = 33'h103;
        for (int k = 0; k < 3; k++) push_exp(AW'(k), IW'(k + 'h100));
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 24'd0;
        @(posedge clk); #1 redirect_valid = 1'b0;
        check("resume_halted", halted, 1'b0);
        wait_head(24'd3);
`else
        push_exp(24'd4, 33'h104);
        push_exp(24'd5, 33'h105);
        pulse_start();
        wait_head(24'd6);
        check("nohalt_flag", halted, 1'b0);
`endif
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
